// File: rtl/tl45_dprf_if.sv
// Register-file access bundle: two combinational read ports, one writeback port and the clear-busy flag.
// The core drives it through the master modport. The register file serves it through the slave modport.
interface tl45_dprf_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic [ADDR_WIDTH-1:0] i_read_a1;
  logic [ADDR_WIDTH-1:0] i_read_a2;
  logic [DATA_WIDTH-1:0] o_d1;
  logic [DATA_WIDTH-1:0] o_d2;
  logic                  i_write_en;
  logic [ADDR_WIDTH-1:0] i_write_addr;
  logic [DATA_WIDTH-1:0] i_write_data;
  logic                  o_busy;

  modport master (
    output i_read_a1, i_read_a2, i_write_en, i_write_addr, i_write_data,
    input  o_d1, o_d2, o_busy
  );

  modport slave (
    input  i_read_a1, i_read_a2, i_write_en, i_write_addr, i_write_data,
    output o_d1, o_d2, o_busy
  );
endinterface

// File: rtl/tl45_dprf.sv
// Dual-read, single-write register file with r0 hardwired to zero and a write-through bypass.
// After reset, a clear sweep zeroes r1..r(NREGS-1), one register per cycle, and holds o_busy high meanwhile.
module tl45_dprf #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  tl45_dprf_if.slave    bus
);

  localparam int NREGS = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_FIRST = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_LAST  = ADDR_WIDTH'(NREGS - 1);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } mode_t;

  mode_t                 mode_q;
  logic [ADDR_WIDTH-1:0] clear_ptr_q;
  logic [DATA_WIDTH-1:0] regs_q [NREGS];

  // Clear sweep restarts at r1 on every reset edge and hands over to RUN after r(NREGS-1).
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mode_q      <= CLEAR;
      clear_ptr_q <= PTR_FIRST;
    end else if (mode_q == CLEAR) begin
      if (clear_ptr_q == PTR_LAST) begin
        mode_q      <= RUN;
        clear_ptr_q <= PTR_FIRST;
      end else begin
        clear_ptr_q <= clear_ptr_q + PTR_FIRST;
      end
    end
  end

  // Storage is never reset directly. The sweep clears it, and writeback is locked out until the sweep ends.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      if (mode_q == CLEAR) begin
        regs_q[clear_ptr_q] <= '0;
      end else if (bus.i_write_en && (bus.i_write_addr != '0)) begin
        regs_q[bus.i_write_addr] <= bus.i_write_data;
      end
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
    logic [DATA_WIDTH-1:0] data;
    data = '0;
    if (addr == '0) begin
      data = '0;
    end else if (mode_q == CLEAR) begin
      data = '0;
    end else if (bus.i_write_en && (bus.i_write_addr == addr)) begin
      data = bus.i_write_data;
    end else begin
      data = regs_q[addr];
    end
    return data;
  endfunction

  assign bus.o_d1   = read_port(bus.i_read_a1);
  assign bus.o_d2   = read_port(bus.i_read_a2);
  assign bus.o_busy = (mode_q == CLEAR);

endmodule

// File: tb/tb_tl45_dprf.sv
// Directed and randomized checks of tl45_dprf: clear sweep timing, bypass, r0, reset behaviour.
module tb_tl45_dprf;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [31:0] ref_q [16];

  always #5 clk = ~clk;

  tl45_dprf_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) bus ();

  tl45_dprf #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] a1, input logic [3:0] a2);
    bus.i_write_en   = we;
    bus.i_write_addr = wa;
    bus.i_write_data = wd;
    bus.i_read_a1    = a1;
    bus.i_read_a2    = a2;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_rd(input logic we, input logic [3:0] wa,
                                         input logic [31:0] wd, input logic [3:0] a);
    if (a == 4'd0) return 32'd0;
    if (we && (wa == a)) return wd;
    return ref_q[a];
  endfunction

  initial begin
    logic        rwe;
    logic [3:0]  rwa, ra1, ra2;
    logic [31:0] rwd;

    for (int k = 0; k < 16; k++) ref_q[k] = 32'd0;

    // T1: reset held for three cycles, then a 15-cycle clear window
    rst = 1'b1;
    drive(1'b0, 4'd0, 32'd0, 4'd5, 4'd9);
    repeat (3) tick();
    chk("rst_busy", 32'(bus.o_busy), 32'd1);
    chk("rst_d1", bus.o_d1, 32'd0);
    chk("rst_d2", bus.o_d2, 32'd0);

    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      // T4: a write to r15 during clear cycle 4 must be dropped
      drive(i == 4, 4'd15, 32'h0000_1234, 4'(i + 1), (i == 4) ? 4'd15 : 4'(14 - i));
      chk("clr_busy", 32'(bus.o_busy), 32'd1);
      chk("clr_d1", bus.o_d1, 32'd0);
      chk("clr_d2", bus.o_d2, 32'd0);
      tick();
    end
    drive(1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
    chk("clr_done_busy", 32'(bus.o_busy), 32'd0);
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 4'd0, 32'd0, 4'(k), 4'(15 - k));
      chk("post_clr_d1", bus.o_d1, 32'd0);
      chk("post_clr_d2", bus.o_d2, 32'd0);
    end

    // T2: same-cycle bypass, then read back from storage
    drive(1'b1, 4'd5, 32'hDEAD_BEEF, 4'd5, 4'd3);
    chk("byp_d1", bus.o_d1, 32'hDEAD_BEEF);
    chk("byp_d2_other", bus.o_d2, 32'd0);
    ref_q[5] = 32'hDEAD_BEEF;
    tick();
    drive(1'b0, 4'd0, 32'd0, 4'd5, 4'd5);
    chk("stor_d1", bus.o_d1, 32'hDEAD_BEEF);
    chk("stor_d2", bus.o_d2, 32'hDEAD_BEEF);

    drive(1'b1, 4'd7, 32'hCAFE_F00D, 4'd7, 4'd7);
    chk("byp_both_d1", bus.o_d1, 32'hCAFE_F00D);
    chk("byp_both_d2", bus.o_d2, 32'hCAFE_F00D);
    ref_q[7] = 32'hCAFE_F00D;
    tick();

    // T3: r0 write is dropped and r0 always reads 0
    drive(1'b1, 4'd0, 32'hFFFF_FFFF, 4'd0, 4'd7);
    chk("r0_same_d1", bus.o_d1, 32'd0);
    chk("r0_same_d2", bus.o_d2, 32'hCAFE_F00D);
    tick();
    drive(1'b0, 4'd3, 32'h55AA_55AA, 4'd0, 4'd3);
    chk("r0_next_d1", bus.o_d1, 32'd0);
    chk("no_we_no_byp_d2", bus.o_d2, 32'd0);
    tick();
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 4'd0, 32'd0, 4'(k), 4'(k));
      chk("scan_d1", bus.o_d1, ref_q[k]);
      chk("scan_d2", bus.o_d2, ref_q[k]);
    end

    // Bypass wins over a stale stored value
    drive(1'b1, 4'd5, 32'h0BAD_F00D, 4'd5, 4'd7);
    chk("byp_over_d1", bus.o_d1, 32'h0BAD_F00D);
    chk("byp_over_d2", bus.o_d2, 32'hCAFE_F00D);
    ref_q[5] = 32'h0BAD_F00D;
    tick();
    drive(1'b0, 4'd0, 32'd0, 4'd5, 4'd5);
    chk("over_stor_d1", bus.o_d1, 32'h0BAD_F00D);

    // Reset mid-RUN: everything reads 0 from the cycle after the reset edge
    rst = 1'b1;
    drive(1'b1, 4'd9, 32'h0000_0099, 4'd5, 4'd7);
    tick();
    chk("run_rst_busy", 32'(bus.o_busy), 32'd1);
    chk("run_rst_d1", bus.o_d1, 32'd0);
    chk("run_rst_d2", bus.o_d2, 32'd0);
    tick();
    rst = 1'b0;
    drive(1'b0, 4'd0, 32'd0, 4'd5, 4'd7);
    // T5: reset again at clear cycle 7, sweep must restart
    for (int i = 0; i < 7; i++) begin
      chk("mid_busy", 32'(bus.o_busy), 32'd1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk("restart_busy", 32'(bus.o_busy), 32'd1);
      chk("restart_d1", bus.o_d1, 32'd0);
      tick();
    end
    chk("restart_done_busy", 32'(bus.o_busy), 32'd0);
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 4'd0, 32'd0, 4'(k), 4'(k));
      chk("restart_scan_d1", bus.o_d1, 32'd0);
      chk("restart_scan_d2", bus.o_d2, 32'd0);
      ref_q[k] = 32'd0;
    end

    // T6: random traffic against the reference array, biased toward collisions
    for (int n = 0; n < 10000; n++) begin
      rwe = 1'($urandom_range(0, 1));
      rwa = 4'($urandom_range(0, 15));
      rwd = $urandom;
      ra1 = ($urandom_range(0, 3) == 0) ? rwa : 4'($urandom_range(0, 15));
      ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 4'($urandom_range(0, 15));
      drive(rwe, rwa, rwd, ra1, ra2);
      chk("rand_d1", bus.o_d1, exp_rd(rwe, rwa, rwd, ra1));
      chk("rand_d2", bus.o_d2, exp_rd(rwe, rwa, rwd, ra2));
      if (rwe && (rwa != 4'd0)) ref_q[rwa] = rwd;
      tick();
    end
    drive(1'b0, 4'd0, 32'd0, 4'd0, 4'd0);
    chk("rand_end_busy", 32'(bus.o_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
